vlc_deser: RTL and testbench
============================

Name: vlc_deser

Overview:
Parametrised serial-to-parallel deserializer for the VLC receive path. It collects WIDTH qualified bits from the slicer/bit-recovery stage into one word. The word is presented on a valid/ready output register to the downstream framer. It supports bit-order selection, partial-word flush, and sticky overflow detection when the downstream side stalls.

Parameters:
- WIDTH, 8, bits per output word; legal range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in out_word[WIDTH-1]; 0: first received bit lands in out_word[0].
- CNT_W, clog2(WIDTH+1), width of bit_count; derived localparam, not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- bit_in  in  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  in  1  qualifies bit_in for this cycle.
- flush  in  1  discards the partial word in progress.
- out_ready  in  1  downstream accepts out_word this cycle.
- clr_ovf  in  1  clears the overflow flag.
- out_word  out  WIDTH  completed word.
- out_valid  out  1  out_word holds an unconsumed word.
- overflow  out  1  sticky; a completed word was dropped.
- bit_count  out  CNT_W  bits accumulated in the current partial word (0..WIDTH-1).

Behaviour:
- Reset (rst=1, asynchronous): shift register=0, bit_count=0, out_word=0, out_valid=0, overflow=0. Reset mid-word discards the partial word and any held output word.
- Accept: on an edge with bit_valid=1 and flush=0, shift bit_in into the shift register and increment bit_count.
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
- Word completion: occurs on the edge that samples a bit while bit_count==WIDTH-1.
  - The full word (shift register plus the new bit) is formed combinationally.
  - bit_count returns to 0 and the shift register clears.
- Output register "free" condition: out_valid=0, or out_valid=1 with out_ready=1 in the same cycle.
  - Word completes and register is free: out_word loads the new word and out_valid=1 after the same edge. Latency from the last bit sampled to out_valid is 1 edge.
  - Word completes and register is not free: the new word is dropped, overflow is set, and out_word is unchanged.
- Handshake:
  - A transfer occurs on an edge where out_valid=1 and out_ready=1.
  - After the transfer, out_valid=0 unless a new word loads on the same edge, in which case out_valid stays 1 and out_word updates.
  - out_word holds stable while out_valid=1 and out_ready=0.
  - out_ready is ignored while out_valid=0.
- flush:
  - Clears the shift register and bit_count on the edge.
  - Priority over bit_valid: a bit presented in the same cycle is discarded.
  - Does not affect out_word, out_valid, or overflow.
- overflow:
  - Set by a dropped word; cleared by clr_ovf.
  - If set and clr_ovf occur on the same edge, set wins and overflow stays 1.
- bit_count never reaches WIDTH; it wraps WIDTH-1 -> 0 at completion.
- No combinational path from bit_in or bit_valid to out_valid. out_ready may combinationally affect only the next-state logic.

Decomposition:
- Shared package vlc_pkg holds:
  - VLC_WORD_W_DEFAULT=8.
  - A clog2 function for CNT_W.
  - An order enum/constant pair: ORDER_LSB_FIRST=0, ORDER_MSB_FIRST=1.
- One sub-module is natural: vlc_word_reg, the single-entry valid/ready output holding register with load/drop/overflow logic.
- The shift/count logic stays in vlc_deser.

Test Plan:
- Basic MSB_FIRST: WIDTH=8, MSB_FIRST=1, out_ready=1, bits 1,1,0,0,0,0,0,0 on consecutive cycles -> out_word=0xC0, out_valid high for exactly 1 cycle after the 8th bit edge, overflow=0.
- Basic LSB_FIRST: same stimulus with MSB_FIRST=0 -> out_word=0x03.
- Backpressure: out_ready=0, send 0xA5 then 0x3C (MSB first, 16 bits) -> first word completes with out_word=0xA5 held; second completion sets overflow=1, out_word stays 0xA5. Raise out_ready -> out_valid drops; assert clr_ovf -> overflow=0.
- Back-to-back with drain: out_ready pulses on the same edge the 2nd word completes -> out_valid stays 1, out_word changes 0xA5->0x3C, overflow=0.
- Flush: send 5 bits, assert flush together with a 6th bit_valid, then send 0xF0 MSB first -> bit_count=0 after flush, out_word=0xF0, no stray word.
- Async reset mid-word: rst pulse after 3 bits with out_valid=1 held -> all outputs 0 immediately (before the next clk edge); the next 8 bits produce the correct word.

Source files
------------

// File: rtl/vlc_pkg.sv
// Shared definitions for the VLC receive-path deserializer: default word width,
// bit-order encoding and the ceiling-log2 helper used to size the bit counter.
package vlc_pkg;

  localparam int VLC_WORD_W_DEFAULT = 8;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } vlc_order_e;

  function automatic int vlc_clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/vlc_word_reg.sv
// Single-entry valid/ready holding register for completed words; a completion
// that finds the register occupied and not draining is dropped and flagged.
module vlc_word_reg
  import vlc_pkg::*;
#(
  parameter int WIDTH = VLC_WORD_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  input  logic             i_clr_ovf,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_ovf;
  logic             w_free;

  assign w_free = ~r_valid | i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (i_load && w_free) begin
        r_word  <= i_word;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      // A drop on the same edge as a clear keeps the flag set.
      if (i_load && !w_free) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_word     = r_word;
  assign o_valid    = r_valid;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/vlc_deser.sv
// Serial-to-parallel deserializer: gathers WIDTH qualified bits into a word and
// hands it to the valid/ready output register, with flush and bit-order select.
module vlc_deser
  import vlc_pkg::*;
#(
  parameter int WIDTH     = VLC_WORD_W_DEFAULT,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W    = vlc_clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             flush,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  output logic             overflow,
  output logic [CNT_W-1:0] bit_count
);

  localparam vlc_order_e ORDER = vlc_order_e'(MSB_FIRST);

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] w_word;
  logic             w_accept;
  logic             w_last;
  logic             w_complete;

  assign w_accept   = bit_valid & ~flush;
  assign w_last     = (r_count == CNT_W'(WIDTH - 1));
  assign w_complete = w_accept & w_last;

  // Next shift-register contents double as the completed word on the last bit.
  assign w_word = (ORDER == ORDER_MSB_FIRST) ? {r_shift[WIDTH-2:0], bit_in}
                                             : {bit_in, r_shift[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (bit_valid) begin
      if (w_last) begin
        r_shift <= '0;
        r_count <= '0;
      end else begin
        r_shift <= w_word;
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bit_count = r_count;

  vlc_word_reg #(
    .WIDTH(WIDTH)
  ) u_word_reg (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_complete),
    .i_word    (w_word),
    .i_ready   (out_ready),
    .i_clr_ovf (clr_ovf),
    .o_word    (out_word),
    .o_valid   (out_valid),
    .o_overflow(overflow)
  );

endmodule

// File: tb/tb_vlc_deser.sv
// Directed bench for vlc_deser: an MSB-first and an LSB-first instance share one
// input stream; expected words are hand-computed per step.
module tb_vlc_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       flush;
  logic       out_ready;
  logic       clr_ovf;

  logic [7:0] m_word;
  logic       m_valid;
  logic       m_ovf;
  logic [3:0] m_cnt;
  logic [7:0] l_word;
  logic       l_valid;
  logic       l_ovf;
  logic [3:0] l_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vlc_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .flush    (flush),
    .out_ready(out_ready),
    .clr_ovf  (clr_ovf),
    .out_word (m_word),
    .out_valid(m_valid),
    .overflow (m_ovf),
    .bit_count(m_cnt)
  );

  vlc_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .flush    (flush),
    .out_ready(out_ready),
    .clr_ovf  (clr_ovf),
    .out_word (l_word),
    .out_valid(l_valid),
    .overflow (l_ovf),
    .bit_count(l_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  // Sends the top n bits of w, most significant first.
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i >= 8 - n; i--) send_bit(w[i]);
  endtask

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0;
    out_ready = 1'b1; clr_ovf = 1'b0;
    #1;
    chk("rst_word", 32'(m_word), 32'h0);
    chk("rst_valid", 32'(m_valid), 32'h0);
    chk("rst_ovf", 32'(m_ovf), 32'h0);
    chk("rst_cnt", 32'(m_cnt), 32'h0);
    #10 rst = 1'b0;
    tick();

    // Basic: 1,1,0,0,0,0,0,0
    send_bits(8'hC0, 7);
    chk("basic_cnt7", 32'(m_cnt), 32'd7);
    chk("basic_no_early_valid", 32'(m_valid), 32'h0);
    send_bit(1'b0);
    chk("basic_msb_word", 32'(m_word), 32'hC0);
    chk("basic_msb_valid", 32'(m_valid), 32'h1);
    chk("basic_lsb_word", 32'(l_word), 32'h03);
    chk("basic_lsb_valid", 32'(l_valid), 32'h1);
    chk("basic_ovf", 32'(m_ovf), 32'h0);
    chk("basic_cnt_wrap", 32'(m_cnt), 32'h0);
    tick();
    chk("basic_valid_1cyc", 32'(m_valid), 32'h0);
    chk("basic_lsb_valid_1cyc", 32'(l_valid), 32'h0);

    // Backpressure: A5 held, 3C dropped
    out_ready = 1'b0;
    send_bits(8'hA5, 8);
    chk("bp_word1", 32'(m_word), 32'hA5);
    chk("bp_valid1", 32'(m_valid), 32'h1);
    tick(); tick();
    chk("bp_hold", 32'(m_word), 32'hA5);
    send_bits(8'h3C, 8);
    chk("bp_ovf_set", 32'(m_ovf), 32'h1);
    chk("bp_word_kept", 32'(m_word), 32'hA5);
    chk("bp_valid_kept", 32'(m_valid), 32'h1);
    out_ready = 1'b1;
    tick();
    chk("bp_drain", 32'(m_valid), 32'h0);
    chk("bp_ovf_sticky", 32'(m_ovf), 32'h1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("bp_ovf_clr", 32'(m_ovf), 32'h0);

    // Back-to-back: drain on the edge the second word completes
    out_ready = 1'b0;
    send_bits(8'hA5, 8);
    chk("b2b_word1", 32'(m_word), 32'hA5);
    send_bits(8'h3C, 7);
    out_ready = 1'b1;
    send_bit(1'b0);
    chk("b2b_valid", 32'(m_valid), 32'h1);
    chk("b2b_word2", 32'(m_word), 32'h3C);
    chk("b2b_ovf", 32'(m_ovf), 32'h0);
    tick();
    chk("b2b_drain", 32'(m_valid), 32'h0);

    // Set beats clear on the same edge
    out_ready = 1'b0;
    send_bits(8'hA5, 8);
    send_bits(8'h3C, 7);
    clr_ovf = 1'b1;
    send_bit(1'b0);
    clr_ovf = 1'b0;
    chk("setwins_ovf", 32'(m_ovf), 32'h1);
    clr_ovf = 1'b1;
    out_ready = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("setwins_clr", 32'(m_ovf), 32'h0);
    chk("setwins_drain", 32'(m_valid), 32'h0);

    // Flush with a simultaneous bit
    send_bits(8'hA8, 5);
    chk("flush_pre_cnt", 32'(m_cnt), 32'd5);
    bit_in = 1'b1; bit_valid = 1'b1; flush = 1'b1;
    tick();
    bit_valid = 1'b0; flush = 1'b0;
    chk("flush_cnt", 32'(m_cnt), 32'h0);
    chk("flush_no_word", 32'(m_valid), 32'h0);
    send_bits(8'hF0, 7);
    chk("flush_no_stray", 32'(m_valid), 32'h0);
    send_bit(1'b0);
    chk("flush_msb_word", 32'(m_word), 32'hF0);
    chk("flush_lsb_word", 32'(l_word), 32'h0F);
    chk("flush_valid", 32'(m_valid), 32'h1);
    tick();

    // Async reset mid-word with a held word and overflow set
    out_ready = 1'b0;
    send_bits(8'hA5, 8);
    send_bits(8'h3C, 8);
    send_bits(8'hA0, 3);
    chk("ar_pre_cnt", 32'(m_cnt), 32'd3);
    chk("ar_pre_ovf", 32'(m_ovf), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("ar_word", 32'(m_word), 32'h0);
    chk("ar_valid", 32'(m_valid), 32'h0);
    chk("ar_ovf", 32'(m_ovf), 32'h0);
    chk("ar_cnt", 32'(m_cnt), 32'h0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    send_bits(8'h96, 8);
    chk("ar_msb_word", 32'(m_word), 32'h96);
    chk("ar_lsb_word", 32'(l_word), 32'h69);
    chk("ar_valid_after", 32'(m_valid), 32'h1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
